// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with an FQ_DEPTH-entry fetch queue.
//
// The stage issues at most one read per cycle to a synchronous instruction
// memory with 1-cycle latency. Responses are queued until decode takes them.
// Branch, jump and ecall redirects flush the queue, kill the pending response
// and issue the target fetch in the same cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_out          memory address for this cycle's request
//   inst_req        memory read enable
//   inst_in         read data, valid the cycle after an accepted inst_req
//   exe_if_jmp_bus  {jmp_flag, jmp_target[31:0], br_flag} from execute
//   ecall_flag      trap redirect from the CSR unit
//   csr_ecall       trap vector
//   ds_allowin      decode can accept this cycle
//   fs_to_ds_valid  head entry valid toward decode
//   if_id_bus_out   {inst[31:0], pc[31:0]} toward decode
//   fq_count        current queue occupancy
//
// Optional feature (macro FQ_BYPASS_EN): a surviving response that finds the
// queue empty while decode is ready is handed to decode in its response cycle
// and is not written into the queue.
//
// Handshake toward decode: an entry transfers on every rising edge where
// fs_to_ds_valid and ds_allowin are both 1. fs_to_ds_valid never depends on
// ds_allowin in the default build; with FQ_BYPASS_EN the bypass path asserts
// valid only when ds_allowin is already 1, so the transfer happens anyway.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [31:0]                      pc_out,
    output logic                             inst_req,
    input  logic [31:0]                      inst_in,
    input  logic [33:0]                      exe_if_jmp_bus,
    input  logic                             ecall_flag,
    input  logic [31:0]                      csr_ecall,
    input  logic                             ds_allowin,
    output logic                             fs_to_ds_valid,
    output logic [63:0]                      if_id_bus_out,
    output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = $clog2(FQ_DEPTH);

    // Registered state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   inst_mem_q [FQ_DEPTH];
    logic [31:0]   pc_mem_q   [FQ_DEPTH];

    // Redirect decode
    logic        jmp_flag;
    logic        br_flag;
    logic [31:0] jmp_target;
    logic        redir;
    logic [31:0] target;

    // Queue control
    logic        empty;
    logic        bypass;
    logic        q_pop;
    logic        push;
    logic [CW:0] occupancy;
    logic        credit;

    assign jmp_flag   = exe_if_jmp_bus[33];
    assign jmp_target = exe_if_jmp_bus[32:1];
    assign br_flag    = exe_if_jmp_bus[0];

    // Branch/jump outranks ecall when both fire together.
    assign redir  = br_flag | jmp_flag | ecall_flag;
    assign target = (br_flag | jmp_flag) ? jmp_target : csr_ecall;

    assign empty = (count_q == '0);

`ifdef FQ_BYPASS_EN
    assign bypass = !rst & inflight_q & !redir & empty & ds_allowin;
`else
    assign bypass = 1'b0;
`endif

    assign fs_to_ds_valid = !rst & !redir & (!empty | bypass);
    // Only a queued head leaves the queue; a bypassed response never entered it.
    assign q_pop = !rst & !redir & !empty & ds_allowin;
    // A response arriving during a redirect belongs to the abandoned path.
    assign push  = !rst & inflight_q & !redir & !bypass;

    // Queued entries plus the outstanding response must fit, so a new request
    // is always safe to accept when this credit holds.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(inflight_q);
    assign credit    = occupancy < (CW + 1)'(FQ_DEPTH);

    assign inst_req = !rst & (redir | credit | (fs_to_ds_valid & ds_allowin));
    assign pc_out   = rst ? RESET_PC : (redir ? target : fetch_pc_q);
    assign fq_count = count_q;

    always_comb begin
        if_id_bus_out = {NOP_INST, pc_mem_q[rd_ptr_q]};
        if (rst) begin
            if_id_bus_out = {NOP_INST, 32'h0000_0000};
        end else if (bypass) begin
            if_id_bus_out = {inst_in, req_pc_q};
        end else if (fs_to_ds_valid) begin
            if_id_bus_out = {inst_mem_q[rd_ptr_q], pc_mem_q[rd_ptr_q]};
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (inst_req) begin
            fetch_pc_d = pc_out + 32'd4;
            inflight_d = 1'b1;
            req_pc_d   = pc_out;
        end

        if (redir) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(q_pop);
            if (q_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= inst_in;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    // The credit rule makes a push into a full queue without a pop impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !q_pop && (count_q == CW'(FQ_DEPTH))));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0033;
  localparam int CW = $clog2(FQ_DEPTH + 1);
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic [31:0]   pc_out;
  logic          inst_req;
  logic [31:0]   inst_in;
  logic [33:0]   exe_if_jmp_bus;
  logic          ecall_flag;
  logic [31:0]   csr_ecall;
  logic          ds_allowin;
  logic          fs_to_ds_valid;
  logic [63:0]   if_id_bus_out;
  logic [CW-1:0] fq_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue #(
    .RESET_PC(RESET_PC),
    .FQ_DEPTH(FQ_DEPTH),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc_out(pc_out),
    .inst_req(inst_req),
    .inst_in(inst_in),
    .exe_if_jmp_bus(exe_if_jmp_bus),
    .ecall_flag(ecall_flag),
    .csr_ecall(csr_ecall),
    .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid),
    .if_id_bus_out(if_id_bus_out),
    .fq_count(fq_count)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // pcs of fetched instructions waiting for decode, oldest first
  logic [31:0] exp_q[$];
  logic        m_inflight;
  logic [31:0] m_ipc;
  logic [31:0] m_fetch;

  // last sampled DUT outputs, for directed checks
  logic [31:0] obs_pc;
  logic        obs_req;
  logic        obs_valid;
  logic [63:0] obs_bus;
  logic [CW-1:0] obs_count;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic ds, input logic jmp, input logic br,
                      input logic ec, input logic [31:0] jt, input logic [31:0] ce);
    logic        redir_e;
    logic [31:0] pc_e;
    logic        byp_e;
    logic        val_e;
    logic        req_e;
    logic [63:0] bus_e;
    int          qs;
    rst            = r;
    ds_allowin     = ds;
    exe_if_jmp_bus = {jmp, jt, br};
    ecall_flag     = ec;
    csr_ecall      = ce;
    inst_in        = m_inflight ? mem_data(m_ipc) : $urandom;
    #1;
    obs_pc    = pc_out;
    obs_req   = inst_req;
    obs_valid = fs_to_ds_valid;
    obs_bus   = if_id_bus_out;
    obs_count = fq_count;
    if (r) begin
      check_eq("rst_req", {63'd0, inst_req}, 64'd0);
      check_eq("rst_pc", {32'd0, pc_out}, {32'd0, RESET_PC});
      check_eq("rst_valid", {63'd0, fs_to_ds_valid}, 64'd0);
      check_eq("rst_bus", if_id_bus_out, {NOP_INST, 32'h0});
      exp_q.delete();
      m_inflight = 1'b0;
      m_fetch    = RESET_PC;
    end else begin
      qs      = exp_q.size();
      redir_e = jmp | br | ec;
      pc_e    = redir_e ? ((jmp | br) ? jt : ce) : m_fetch;
      byp_e   = BYP && m_inflight && !redir_e && (qs == 0) && ds;
      val_e   = !redir_e && ((qs > 0) || byp_e);
      req_e   = redir_e || ((qs + int'(m_inflight)) < FQ_DEPTH) || (val_e && ds);
      check_eq("pc_out", {32'd0, pc_out}, {32'd0, pc_e});
      check_eq("inst_req", {63'd0, inst_req}, {63'd0, req_e});
      check_eq("valid", {63'd0, fs_to_ds_valid}, {63'd0, val_e});
      check_eq("fq_count", {{(64-CW){1'b0}}, fq_count}, 64'(qs));
      if (byp_e) begin
        bus_e = {mem_data(m_ipc), m_ipc};
        check_eq("bus_bypass", if_id_bus_out, bus_e);
      end else if (qs > 0) begin
        bus_e = val_e ? {mem_data(exp_q[0]), exp_q[0]} : {NOP_INST, exp_q[0]};
        check_eq("bus_head", if_id_bus_out, bus_e);
      end else begin
        check_eq("bus_nop", {32'd0, if_id_bus_out[63:32]}, {32'd0, NOP_INST});
      end
      if (redir_e) begin
        exp_q.delete();
      end else begin
        if (val_e && ds && !byp_e) void'(exp_q.pop_front());
        if (m_inflight && !byp_e) exp_q.push_back(m_ipc);
      end
      if (req_e) begin
        m_fetch    = pc_e + 32'd4;
        m_inflight = 1'b1;
        m_ipc      = pc_e;
      end else begin
        m_inflight = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ds);
    step(1'b0, ds, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] popped[$];
    logic [31:0] first_pc;
    logic        found;
    logic        ds;
    logic        jmp, br, ec;
    logic [31:0] jt, ce;
    int          sel;

    rst = 1'b1; ds_allowin = 1'b0; exe_if_jmp_bus = '0;
    ecall_flag = 1'b0; csr_ecall = '0; inst_in = '0;
    m_inflight = 1'b0; m_ipc = '0; m_fetch = RESET_PC;
    @(posedge clk);
    #1;

    // 1. streaming after reset
    do_reset();
    idle(1'b1);
    check_eq("t1_pc0", {32'd0, obs_pc}, 64'h0);
    check_eq("t1_valid0", {63'd0, obs_valid}, 64'd0);
    idle(1'b1);
    check_eq("t1_pc1", {32'd0, obs_pc}, 64'h4);
    check_eq("t1_valid1", {63'd0, obs_valid}, {63'd0, BYP});
    idle(1'b1);
    check_eq("t1_pc2", {32'd0, obs_pc}, 64'h8);
    check_eq("t1_valid2", {63'd0, obs_valid}, 64'd1);
    check_eq("t1_bus_pc2", {32'd0, obs_bus[31:0]}, BYP ? 64'h4 : 64'h0);

    // 2. decode stall fills the queue, release drains in order
    do_reset();
    for (int i = 0; i < 10; i++) idle(1'b0);
    check_eq("t2_count_sat", {{(64-CW){1'b0}}, obs_count}, 64'(FQ_DEPTH));
    check_eq("t2_req_off", {63'd0, obs_req}, 64'd0);
    popped.delete();
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      if (obs_valid) popped.push_back(obs_bus[31:0]);
    end
    check_eq("t2_npop", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      first_pc = (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
      check_eq("t2_order", {32'd0, first_pc}, 64'(4 * i));
    end

    // 3. branch flush with three queued entries
    do_reset();
    for (int i = 0; i < 4; i++) idle(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    check_eq("t3_count_before", {{(64-CW){1'b0}}, obs_count}, 64'd3);
    check_eq("t3_pc_tgt", {32'd0, obs_pc}, 64'h100);
    check_eq("t3_valid_kill", {63'd0, obs_valid}, 64'd0);
    idle(1'b0);
    check_eq("t3_count_flush", {{(64-CW){1'b0}}, obs_count}, 64'd0);
    found = 1'b0; first_pc = 32'hDEAD_DEAD;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (obs_valid && !found) begin found = 1'b1; first_pc = obs_bus[31:0]; end
    end
    check_eq("t3_first_pc", {32'd0, first_pc}, 64'h100);

    // 4. jump outranks simultaneous ecall
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h200);
    check_eq("t4_pc", {32'd0, obs_pc}, 64'h80);
    found = 1'b0; first_pc = 32'hDEAD_DEAD;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (obs_valid && !found) begin found = 1'b1; first_pc = obs_bus[31:0]; end
    end
    check_eq("t4_first_pc", {32'd0, first_pc}, 64'h80);

    // 5. fetch address wraps
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    idle(1'b1);
    check_eq("t5_wrap", {32'd0, obs_pc}, 64'h0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 6. reset while busy drops everything
    do_reset();
    for (int i = 0; i < 8; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b1);
    check_eq("t6_count", {{(64-CW){1'b0}}, obs_count}, 64'd0);
    check_eq("t6_valid", {63'd0, obs_valid}, 64'd0);
    check_eq("t6_pc", {32'd0, obs_pc}, {32'd0, RESET_PC});
    check_eq("t6_req", {63'd0, obs_req}, 64'd1);

    // 7. random traffic
    for (int n = 0; n < 1500; n++) begin
      ds  = ($urandom_range(0, 9) < 7);
      sel = $urandom_range(0, 19);
      jmp = (sel == 0) || (sel == 3);
      br  = (sel == 1);
      ec  = (sel == 2) || (sel == 3);
      jt  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                        : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ce  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step(($urandom_range(0, 99) == 0), ds, jmp, br, ec, jt, ce);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor of the single-entry fetch stage.
- Decouples instruction fetch from decode with an FQ_DEPTH-entry fetch queue.
- Issues at most one request per cycle to a synchronous instruction memory with 1-cycle latency, and handles redirects (branch, jump, ecall) with a full flush.
- Sits between the instruction memory and the decode stage; redirects arrive from execute and the CSR unit.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FQ_DEPTH, 4, queue entries; power of two, at least 2.
- NOP_INST, 32'h0000_0033, instruction driven when the output is invalid (ADD x0,x0,x0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_out  out  32  instruction memory address for this cycle's request.
- inst_req  out  1  instruction memory read enable.
- inst_in  in  32  read data, valid the cycle after an accepted inst_req.
- exe_if_jmp_bus  in  34  {jmp_flag, jmp_target[31:0], br_flag}.
- ecall_flag  in  1  trap redirect.
- csr_ecall  in  32  trap vector.
- ds_allowin  in  1  decode can accept.
- fs_to_ds_valid  out  1  head entry valid toward decode.
- if_id_bus_out  out  64  {inst[31:0], pc[31:0]}.
- fq_count  out  $clog2(FQ_DEPTH+1)  current queue occupancy.

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset values: fetch_pc=RESET_PC; queue empty; inflight=0; fq_count=0.
- Outputs while rst=1: inst_req=0, pc_out=RESET_PC, fs_to_ds_valid=0, if_id_bus_out={NOP_INST,32'h0}.
- Redirect: redir = br_flag|jmp_flag|ecall_flag.
  - Target is jmp_target if br_flag|jmp_flag; otherwise csr_ecall.
  - Branch/jump has priority over ecall when both are asserted.
- pc_out = redir ? target : fetch_pc (combinational).
- pop = fs_to_ds_valid & ds_allowin.
- inst_req = !rst & (redir | (fq_count + inflight < FQ_DEPTH) | pop).
  - The credit rule guarantees no overflow.
  - Full one-request-per-cycle throughput is sustained for any FQ_DEPTH >= 2 when decode never stalls.
- On an accepted request:
  - fetch_pc <= pc_out + 4 (mod 2^32; wraps 32'hFFFF_FFFC -> 0).
  - inflight <= 1 and req_pc <= pc_out.
  - With no request, inflight <= 0.
- Response cycle (inflight=1): push {inst_in, req_pc} into the queue, unless redir is asserted that cycle. A killed response is discarded.
- Redirect cycle:
  - Whole queue flushed (count <= 0, pointers reset).
  - Pending response killed; the target request is issued the same cycle.
  - fs_to_ds_valid is forced to 0 during the redirect cycle.
- Output:
  - fs_to_ds_valid = !empty & !redir.
  - if_id_bus_out = fs_to_ds_valid ? head : {NOP_INST, head_pc}.
- Push and pop in the same cycle: count unchanged; push when full cannot occur (must never happen; flag with an assertion).
- Latency without bypass: request at cycle T -> inst_in at T+1 -> fs_to_ds_valid at T+2.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight response is dropped.

Optional Feature:
- Macro FQ_BYPASS_EN.
- Defined: a non-killed response arriving with the queue empty and ds_allowin=1 goes straight to if_id_bus_out with fs_to_ds_valid=1 in the response cycle (T+1) and is not pushed.
  - If ds_allowin=0, or the queue is non-empty, the response is pushed as normal.
  - Ordering is always preserved.
- Undefined: every response goes through the queue, giving 2-cycle request-to-valid latency.

Test Plan:
- Reset release, ds_allowin=1, memory returns pc-derived data -> pc_out 0,4,8,... on consecutive cycles; first fs_to_ds_valid at cycle 2 (cycle 1 with FQ_BYPASS_EN) carrying pc=0.
- Hold ds_allowin=0 for 10 cycles, FQ_DEPTH=4 -> fq_count saturates at 4, inst_req drops to 0, and no entry is lost. On release, pcs 0,4,8,12,16 emerge in order.
- Queue holding 3 entries, br_flag=1 with jmp_target=32'h100 -> same cycle pc_out=32'h100 and fs_to_ds_valid=0. Next cycle fq_count=0 and the old response is not pushed. Next valid pc=32'h100.
- ecall_flag=1 with csr_ecall=32'h200 together with jmp_flag=1, jmp_target=32'h80 -> pc_out=32'h80; subsequent stream starts at 32'h80.
- fetch_pc=32'hFFFF_FFFC issued -> next pc_out=32'h0000_0000.
- rst asserted for 1 cycle while full with one request in flight -> next cycle fq_count=0, fs_to_ds_valid=0, and the stale response is dropped. First request after reset has pc_out=RESET_PC.
